bpm_uart_reporter: RTL and testbench
====================================

Name: bpm_uart_reporter

Overview:
Transmit side of the BPM link. Watches the BPM period register and its change strobe, and frames the current value into UART TX bytes. It then hands those bytes to the UART transmitter over a valid/ready byte interface. The host therefore sees every button-driven or UART-driven BPM change. Sits beside bpm_counter, feeding the uart_tx byte input.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame
GAP_CYCLES, 16, idle i_clk cycles enforced after a frame's last byte handshake before the next frame may start (0 allowed = no gap)

Ports:
i_clk  input  1  clock
i_reset  input  1  asynchronous, active-high reset
i_bpm_counter  input  34  current BPM period count (registered; updates the cycle after i_bpm_changed)
i_bpm_changed  input  1  single-or-multi-cycle strobe, value changes on next clock
o_tx_data  output  8  byte to transmit
o_tx_valid  output  1  o_tx_data valid
i_tx_ready  input  1  transmitter accepts byte this cycle
o_busy  output  1  frame in progress or gap running
o_saturated  output  1  one-cycle pulse when a captured value exceeded 32 bits

Behaviour:
- Reset (async): o_tx_data=0, o_tx_valid=0, o_busy=0, o_saturated=0, pending=0, FSM=IDLE, byte index=0, gap counter=0. Reset mid-frame aborts the frame; no partial resume.
- Byte transfer occurs on a rising edge with o_tx_valid&&i_tx_ready. While valid&&!ready, o_tx_data and o_tx_valid hold stable. Valid is never withdrawn without a transfer, except by reset.
- pending flag: set on any cycle with i_bpm_changed=1, in any state. Cleared in CAPTURE. Changes during a frame coalesce into exactly one follow-up frame.
- FSM:
  IDLE: pending=1 -> CAPTURE (one cycle later, so i_bpm_counter already holds the new value).
  CAPTURE: latch value. If i_bpm_counter[33:32]!=0, latch 32'hFFFF_FFFF and pulse o_saturated; else latch [31:0]. Clear pending; clear checksum accumulator. -> SYNC.
  SYNC: o_tx_data=SYNC_BYTE, valid=1; on transfer -> DATA, index=0.
  DATA: send latched bytes big-endian, index 0..3 = [31:24],[23:16],[15:8],[7:0]. XOR each sent byte into the checksum. On transfer of index 3 -> CHK (feature on) or GAP (feature off).
  CHK: o_tx_data = XOR of the four data bytes; on transfer -> GAP.
  GAP: count GAP_CYCLES cycles, then -> IDLE. GAP_CYCLES=0 -> IDLE next cycle.
- A change in the same cycle as CAPTURE sets pending again (set wins over clear), giving a follow-up frame.
- o_busy=1 in every state except IDLE.
- Frame latency: first valid (SYNC) asserts 2 cycles after the i_bpm_changed edge sample (IDLE->CAPTURE->SYNC).
- Value is snapshotted in CAPTURE; later i_bpm_counter changes never alter an in-flight frame.

Optional Feature:
BPM_REPORT_CHECKSUM_EN: defined -> CHK state present; frame is 6 bytes (SYNC, B3, B2, B1, B0, XOR). Undefined -> no CHK state or accumulator; frame is 5 bytes, DATA index 3 goes directly to GAP.

Test Plan:
- Pulse i_bpm_changed, next cycle i_bpm_counter=34'h0_1234_5678, i_tx_ready=1 -> bytes A5,12,34,56,78,(checksum 08 if EN); o_saturated stays 0; o_busy drops GAP_CYCLES after last transfer.
- Same frame with i_tx_ready toggling 1-of-3 cycles -> identical byte sequence; o_tx_data stable during every stall.
- i_bpm_counter=34'h2_0000_0001 -> data bytes FF,FF,FF,FF; o_saturated single pulse in CAPTURE; checksum 00.
- Three i_bpm_changed pulses during one frame; final value 34'h0_0000_00C8 -> exactly one follow-up frame carrying 00,00,00,C8.
- Assert i_reset after the 2nd data byte -> o_tx_valid=0 and o_busy=0 immediately; after release, no bytes until a new i_bpm_changed.
- GAP_CYCLES=0 with changes back-to-back -> second SYNC valid exactly 2 cycles after the first frame's last transfer.

Source files
------------

// File: rtl/bpm_uart_reporter.sv
// BPM transmit framer: snapshots the BPM period on change and emits SYNC + 4 big-endian bytes over valid/ready.
// Define BPM_REPORT_CHECKSUM_EN to append an XOR checksum byte (6-byte frames instead of 5).
module bpm_uart_reporter #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         GAP_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [33:0] i_bpm_counter,
    input  logic        i_bpm_changed,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_saturated
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_SYNC,
        S_DATA,
        S_CHK,
        S_GAP
    } state_t;

    // With no gap configured the last byte returns straight to IDLE.
    localparam state_t S_AFTER = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

    state_t             state_q, state_d;
    logic               pending_q, pending_d;
    logic [31:0]        value_q, value_d;
    logic [1:0]         idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         data_byte;
`ifdef BPM_REPORT_CHECKSUM_EN
    logic [7:0]         chk_q, chk_d;
`endif

    function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] i);
        case (i)
            2'd0:    return v[31:24];
            2'd1:    return v[23:16];
            2'd2:    return v[15:8];
            default: return v[7:0];
        endcase
    endfunction

    assign data_byte = byte_sel(value_q, idx_q);
    assign o_busy    = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        value_d     = value_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        o_tx_data   = 8'h00;
        o_tx_valid  = 1'b0;
        o_saturated = 1'b0;
`ifdef BPM_REPORT_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pending_q) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                pending_d = 1'b0;
                if (i_bpm_counter[33:32] != 2'b00) begin
                    value_d     = 32'hFFFF_FFFF;
                    o_saturated = 1'b1;
                end else begin
                    value_d = i_bpm_counter[31:0];
                end
`ifdef BPM_REPORT_CHECKSUM_EN
                chk_d = 8'h00;
`endif
                state_d = S_SYNC;
            end
            S_SYNC: begin
                o_tx_data  = SYNC_BYTE;
                o_tx_valid = 1'b1;
                if (i_tx_ready) begin
                    state_d = S_DATA;
                    idx_d   = 2'd0;
                end
            end
            S_DATA: begin
                o_tx_data  = data_byte;
                o_tx_valid = 1'b1;
                if (i_tx_ready) begin
                    idx_d = idx_q + 2'd1;
`ifdef BPM_REPORT_CHECKSUM_EN
                    chk_d = chk_q ^ data_byte;
`endif
                    if (idx_q == 2'd3) begin
                        gap_d = '0;
`ifdef BPM_REPORT_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_AFTER;
`endif
                    end
                end
            end
`ifdef BPM_REPORT_CHECKSUM_EN
            S_CHK: begin
                o_tx_data  = chk_q;
                o_tx_valid = 1'b1;
                if (i_tx_ready) begin
                    gap_d   = '0;
                    state_d = S_AFTER;
                end
            end
`endif
            S_GAP: begin
                if (int'(gap_q) >= GAP_CYCLES - 1) state_d = S_IDLE;
                else                                gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // A change landing in CAPTURE must still produce a follow-up frame.
        if (i_bpm_changed) pending_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            value_q   <= 32'h0;
            idx_q     <= 2'd0;
            gap_q     <= '0;
`ifdef BPM_REPORT_CHECKSUM_EN
            chk_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            value_q   <= value_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
`ifdef BPM_REPORT_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_bpm_uart_reporter.sv
// Scoreboard bench for bpm_uart_reporter: a frame-level model queues expected bytes, a monitor checks handshakes.
`timescale 1ns/1ps
module tb_bpm_uart_reporter;
    localparam int         GAP  = 16;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef BPM_REPORT_CHECKSUM_EN
    localparam int FLEN = 6;
`else
    localparam int FLEN = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [33:0] cnt;
    logic        chg;
    logic [7:0]  txd;
    logic        txv;
    logic        rdy;
    logic        busy;
    logic        sat;

    logic [33:0] z_cnt;
    logic        z_chg;
    logic [7:0]  z_txd;
    logic        z_txv;
    logic        z_rdy;
    logic        z_busy;
    logic        z_sat;

    bpm_uart_reporter #(.SYNC_BYTE(SYNC), .GAP_CYCLES(GAP)) dut (
        .i_clk(clk), .i_reset(rst), .i_bpm_counter(cnt), .i_bpm_changed(chg),
        .o_tx_data(txd), .o_tx_valid(txv), .i_tx_ready(rdy), .o_busy(busy), .o_saturated(sat)
    );

    bpm_uart_reporter #(.SYNC_BYTE(SYNC), .GAP_CYCLES(0)) dut_z (
        .i_clk(clk), .i_reset(rst), .i_bpm_counter(z_cnt), .i_bpm_changed(z_chg),
        .o_tx_data(z_txd), .o_tx_valid(z_txv), .i_tx_ready(z_rdy), .o_busy(z_busy), .o_saturated(z_sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         passed = 0;
    int         total  = 0;
    logic [7:0] expq[$];
    int         exp_sat = 0;
    int         got_sat = 0;
    int         xfers = 0;
    int         byte_idx = 0;
    int         last_edge = -1;
    int         rdy_mode = 0;
    logic       stalled = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic       prev_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // Frame contents derived directly from the value: SYNC, big-endian word, optional XOR.
    function automatic logic [7:0] frame_byte(input logic [33:0] v, input int i);
        logic [31:0] w;
        w = (v[33:32] != 2'b00) ? 32'hFFFF_FFFF : v[31:0];
        case (i)
            0:       return SYNC;
            1:       return w[31:24];
            2:       return w[23:16];
            3:       return w[15:8];
            4:       return w[7:0];
            default: return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        endcase
    endfunction

    task automatic push_frame(input logic [33:0] v);
        for (int i = 0; i < FLEN; i++) expq.push_back(frame_byte(v, i));
        if (v[33:32] != 2'b00) exp_sat++;
    endtask

    task automatic change(input logic [33:0] v);
        @(posedge clk); #1 chg = 1'b1;
        @(posedge clk); #1 chg = 1'b0; cnt = v;
    endtask

    task automatic send(input logic [33:0] v);
        push_frame(v);
        change(v);
    endtask

    task automatic wait_xfers(input int n);
        int k = 0;
        while (xfers < n && k < 2000) begin
            @(negedge clk); #1;
            k++;
        end
        if (xfers < n) begin
            total++;
            $display("FAIL wait_xfers: got %0d required %0d", xfers, n);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        repeat (3) @(posedge clk);
        while ((busy || expq.size() != 0) && k < 3000) begin
            @(negedge clk); #1;
            k++;
        end
        if (busy || expq.size() != 0) begin
            total++;
            $display("FAIL wait_idle: busy %0d pending bytes %0d required 0", busy, expq.size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom % 2);
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (stalled) check("stall_hold", {55'd0, txv, txd}, {55'd0, 1'b1, stall_data});
            stalled    = txv && !rdy;
            stall_data = txd;
            if (sat) got_sat++;
            if (txv && rdy) begin
                if (expq.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_byte: got %0h required none", txd);
                end else begin
                    check("byte", txd, expq.pop_front());
                end
                xfers++;
                byte_idx++;
                if (byte_idx == FLEN) begin
                    byte_idx  = 0;
                    last_edge = cyc + 1;
                end
            end
            if (prev_busy && !busy && last_edge >= 0) begin
                check("gap_len", cyc - last_edge, GAP);
                last_edge = -1;
            end
            prev_busy = busy;
        end else begin
            stalled   = 1'b0;
            byte_idx  = 0;
            last_edge = -1;
            prev_busy = 1'b0;
        end
    end

    logic [7:0] zgot[$];
    int         zlast = -1;
    int         zrise = -1;
    int         zsat = 0;
    logic       zprev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (z_sat) zsat++;
            if (z_txv && !zprev && zgot.size() == FLEN) zrise = cyc;
            if (z_txv && z_rdy) begin
                zgot.push_back(z_txd);
                if (zgot.size() == FLEN) zlast = cyc + 1;
            end
            zprev = z_txv;
        end
    end

    initial begin
        int base;
        logic [33:0] v;
        rst = 1'b1; chg = 1'b0; cnt = '0; rdy = 1'b1;
        z_chg = 1'b0; z_cnt = '0; z_rdy = 1'b1;
        #1;
        check("rst_data", txd, 0);
        check("rst_valid", txv, 0);
        check("rst_busy", busy, 0);
        check("rst_sat", sat, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        rdy_mode = 0; send(34'h0_1234_5678); wait_idle();
        rdy_mode = 1; send(34'h0_1234_5678); wait_idle();
        rdy_mode = 0; send(34'h2_0000_0001); wait_idle();

        base = xfers;
        send(34'h0_0000_0010);
        wait_xfers(base + 2);
        change(34'h1_1111_1111);
        change(34'h0_0000_0077);
        change(34'h0_0000_00C8);
        push_frame(34'h0_0000_00C8);
        wait_idle();

        for (int it = 0; it < 20; it++) begin
            rdy_mode = $urandom % 3;
            v = {(($urandom % 4) == 0) ? 2'(1 + $urandom % 3) : 2'b00, 32'($urandom)};
            base = xfers;
            send(v);
            if ($urandom % 2 == 1) begin
                int nb = 1 + $urandom % 3;
                wait_xfers(base + 1);
                for (int j = 0; j < nb; j++) begin
                    v = {2'($urandom % 4), 32'($urandom)};
                    change(v);
                end
                push_frame(v);
            end
            wait_idle();
        end

        rdy_mode = 0;
        base = xfers;
        send(34'h0_1234_5678);
        wait_xfers(base + 3);
        @(posedge clk); #2 rst = 1'b1; #1;
        check("mid_rst_valid", txv, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", txd, 0);
        expq.delete();
        @(posedge clk); #1 rst = 1'b0;
        base = xfers;
        repeat (25) @(posedge clk);
        check("no_resume", xfers, base);
        check("idle_after_rst", busy, 0);

        @(posedge clk); #1 z_chg = 1'b1;
        @(posedge clk); #1 z_chg = 1'b0; z_cnt = 34'h0_DEAD_BEEF;
        begin
            int k = 0;
            while (zgot.size() < 1 && k < 100) begin
                @(negedge clk); #1;
                k++;
            end
        end
        @(posedge clk); #1 z_chg = 1'b1;
        @(posedge clk); #1 z_chg = 1'b0; z_cnt = 34'h3_0000_0000;
        repeat (30) @(posedge clk);
        check("z_count", zgot.size(), 2 * FLEN);
        if (zgot.size() == 2 * FLEN) begin
            for (int i = 0; i < FLEN; i++) begin
                check("z_frame1", zgot[i], frame_byte(34'h0_DEAD_BEEF, i));
                check("z_frame2", zgot[FLEN + i], frame_byte(34'h3_0000_0000, i));
            end
        end
        check("z_gap0_latency", zrise - zlast, 2);
        check("z_sat", zsat, 1);

        check("queue_empty", expq.size(), 0);
        check("sat_count", got_sat, exp_sat);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
